// File: rtl/clct_pretrig_sequencer.sv
// CLCT pre-trigger sequencer: pre-triggers on the sorter's best pattern, waits out the drift
// delay, re-qualifies and latches a CLCT, then holds off for a dead time before re-arming.
module clct_pretrig_sequencer #(
    parameter int unsigned MXPATB  = 7,
    parameter int unsigned MXKEYBX = 8,
    parameter int unsigned MXXKYB  = 10,
    parameter int unsigned MXBNDB  = 5,
    parameter int unsigned MXPATC  = 12,
    parameter int unsigned MXQLTB  = 6,
    parameter int unsigned MXCNTB  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [MXPATB-1:0]  best_pat,
    input  logic [MXKEYBX-1:0] best_key,
    input  logic [MXBNDB-1:0]  best_bend,
    input  logic [MXPATC-1:0]  best_carry,
    input  logic [MXXKYB-1:0]  best_subkey,
    input  logic [MXQLTB-1:0]  best_qlt,
    input  logic               seq_en,
    input  logic [2:0]         hit_thresh_pretrig,
    input  logic [3:0]         pid_thresh_pretrig,
    input  logic [2:0]         hit_thresh_postdrift,
    input  logic [3:0]         pid_thresh_postdrift,
    input  logic [1:0]         drift_delay,
    input  logic [3:0]         dead_time,
    input  logic               cnt_clear,
    output logic               pretrig,
    output logic               busy,
    output logic               clct_vld,
    output logic [2:0]         clct_hit,
    output logic [3:0]         clct_pid,
    output logic [MXKEYBX-1:0] clct_key,
    output logic [MXXKYB-1:0]  clct_subkey,
    output logic [MXBNDB-1:0]  clct_bend,
    output logic [MXPATC-1:0]  clct_carry,
    output logic [MXQLTB-1:0]  clct_qlt,
    output logic [MXCNTB-1:0]  cnt_pretrig,
    output logic [MXCNTB-1:0]  cnt_clct,
    output logic [MXCNTB-1:0]  cnt_drop,
    output logic [MXCNTB-1:0]  cnt_blocked
);

    typedef enum logic [1:0] {StIdle, StDrift, StEval, StDead} state_e;

    state_e state_q, state_d;
    logic [3:0] timer_q, timer_d;

    logic pretrig_q, pretrig_d;
    logic clct_vld_q, clct_vld_d;

    logic [2:0]         hit_q, hit_d;
    logic [3:0]         pid_q, pid_d;
    logic [MXKEYBX-1:0] key_q, key_d;
    logic [MXXKYB-1:0]  subkey_q, subkey_d;
    logic [MXBNDB-1:0]  bend_q, bend_d;
    logic [MXPATC-1:0]  carry_q, carry_d;
    logic [MXQLTB-1:0]  qlt_q, qlt_d;

    logic [MXCNTB-1:0] cnt_pretrig_q, cnt_clct_q, cnt_drop_q, cnt_blocked_q;
    logic inc_pretrig, inc_clct, inc_drop, inc_blocked;

    logic [2:0] pat_hits;
    logic [3:0] pat_pid;
    logic       pre_ok;
    logic       post_ok;

    assign pat_hits = best_pat[6:4];
    assign pat_pid  = best_pat[3:0];

    assign pre_ok  = (pat_hits >= hit_thresh_pretrig) && (pat_pid >= pid_thresh_pretrig);
    assign post_ok = (pat_hits >= hit_thresh_postdrift) && (pat_pid >= pid_thresh_postdrift);

    assign busy        = (state_q != StIdle);
    assign inc_blocked = busy && seq_en && pre_ok;

    // Saturating counter step; a clear wins over a same-cycle increment.
    function automatic logic [MXCNTB-1:0] cnt_step(input logic [MXCNTB-1:0] cur,
                                                   input logic inc, input logic clr);
        if (clr) begin
            return '0;
        end else if (inc && (cur != {MXCNTB{1'b1}})) begin
            return cur + 1'b1;
        end
        return cur;
    endfunction

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pretrig_d   = 1'b0;
        clct_vld_d  = 1'b0;
        hit_d       = hit_q;
        pid_d       = pid_q;
        key_d       = key_q;
        subkey_d    = subkey_q;
        bend_d      = bend_q;
        carry_d     = carry_q;
        qlt_d       = qlt_q;
        inc_pretrig = 1'b0;
        inc_clct    = 1'b0;
        inc_drop    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (seq_en && pre_ok) begin
                    pretrig_d   = 1'b1;
                    inc_pretrig = 1'b1;
                    // The pretrig cycle itself is the first drift cycle, so the timer
                    // holds the number of drift cycles still to run after it.
                    if (drift_delay == 2'd0) begin
                        state_d = StEval;
                    end else begin
                        state_d = StDrift;
                        timer_d = {2'b00, drift_delay} - 4'd1;
                    end
                end
            end
            StDrift: begin
                if (timer_q == 4'd0) begin
                    state_d = StEval;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            StEval: begin
                if (post_ok) begin
                    clct_vld_d = 1'b1;
                    inc_clct   = 1'b1;
                    hit_d      = pat_hits;
                    pid_d      = pat_pid;
                    key_d      = best_key;
                    subkey_d   = best_subkey;
                    bend_d     = best_bend;
                    carry_d    = best_carry;
                    qlt_d      = best_qlt;
                end else begin
                    inc_drop = 1'b1;
                end
                if (dead_time == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    state_d = StDead;
                    timer_d = dead_time - 4'd1;
                end
            end
            StDead: begin
                if (timer_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            timer_q       <= 4'd0;
            pretrig_q     <= 1'b0;
            clct_vld_q    <= 1'b0;
            hit_q         <= '0;
            pid_q         <= '0;
            key_q         <= '0;
            subkey_q      <= '0;
            bend_q        <= '0;
            carry_q       <= '0;
            qlt_q         <= '0;
            cnt_pretrig_q <= '0;
            cnt_clct_q    <= '0;
            cnt_drop_q    <= '0;
            cnt_blocked_q <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pretrig_q     <= pretrig_d;
            clct_vld_q    <= clct_vld_d;
            hit_q         <= hit_d;
            pid_q         <= pid_d;
            key_q         <= key_d;
            subkey_q      <= subkey_d;
            bend_q        <= bend_d;
            carry_q       <= carry_d;
            qlt_q         <= qlt_d;
            cnt_pretrig_q <= cnt_step(cnt_pretrig_q, inc_pretrig, cnt_clear);
            cnt_clct_q    <= cnt_step(cnt_clct_q, inc_clct, cnt_clear);
            cnt_drop_q    <= cnt_step(cnt_drop_q, inc_drop, cnt_clear);
            cnt_blocked_q <= cnt_step(cnt_blocked_q, inc_blocked, cnt_clear);
        end
    end

    assign pretrig     = pretrig_q;
    assign clct_vld    = clct_vld_q;
    assign clct_hit    = hit_q;
    assign clct_pid    = pid_q;
    assign clct_key    = key_q;
    assign clct_subkey = subkey_q;
    assign clct_bend   = bend_q;
    assign clct_carry  = carry_q;
    assign clct_qlt    = qlt_q;
    assign cnt_pretrig = cnt_pretrig_q;
    assign cnt_clct    = cnt_clct_q;
    assign cnt_drop    = cnt_drop_q;
    assign cnt_blocked = cnt_blocked_q;

endmodule

// File: tb/tb_clct_pretrig_sequencer.sv
// Scoreboard bench for clct_pretrig_sequencer: stimulus queues expected pretrig/CLCT events,
// a negedge monitor pops and compares them; counters and status are checked directly.
module tb_clct_pretrig_sequencer;

    localparam int unsigned CNTW = 8;  // narrow counters so saturation is reachable quickly

    logic            clock = 1'b0;
    logic            reset;
    logic [6:0]      best_pat;
    logic [7:0]      best_key;
    logic [4:0]      best_bend;
    logic [11:0]     best_carry;
    logic [9:0]      best_subkey;
    logic [5:0]      best_qlt;
    logic            seq_en;
    logic [2:0]      hit_thresh_pretrig, hit_thresh_postdrift;
    logic [3:0]      pid_thresh_pretrig, pid_thresh_postdrift;
    logic [1:0]      drift_delay;
    logic [3:0]      dead_time;
    logic            cnt_clear;
    logic            pretrig, busy, clct_vld;
    logic [2:0]      clct_hit;
    logic [3:0]      clct_pid;
    logic [7:0]      clct_key;
    logic [9:0]      clct_subkey;
    logic [4:0]      clct_bend;
    logic [11:0]     clct_carry;
    logic [5:0]      clct_qlt;
    logic [CNTW-1:0] cnt_pretrig, cnt_clct, cnt_drop, cnt_blocked;

    clct_pretrig_sequencer #(.MXCNTB(CNTW)) dut (
        .clock(clock), .reset(reset),
        .best_pat(best_pat), .best_key(best_key), .best_bend(best_bend),
        .best_carry(best_carry), .best_subkey(best_subkey), .best_qlt(best_qlt),
        .seq_en(seq_en),
        .hit_thresh_pretrig(hit_thresh_pretrig), .pid_thresh_pretrig(pid_thresh_pretrig),
        .hit_thresh_postdrift(hit_thresh_postdrift), .pid_thresh_postdrift(pid_thresh_postdrift),
        .drift_delay(drift_delay), .dead_time(dead_time), .cnt_clear(cnt_clear),
        .pretrig(pretrig), .busy(busy), .clct_vld(clct_vld),
        .clct_hit(clct_hit), .clct_pid(clct_pid), .clct_key(clct_key),
        .clct_subkey(clct_subkey), .clct_bend(clct_bend), .clct_carry(clct_carry),
        .clct_qlt(clct_qlt),
        .cnt_pretrig(cnt_pretrig), .cnt_clct(cnt_clct), .cnt_drop(cnt_drop),
        .cnt_blocked(cnt_blocked)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Expected CLCT: cycle of the strobe and {hit,pid,key,subkey,bend,carry,qlt}.
    typedef struct {
        int          at;
        logic [47:0] fields;
    } clct_exp_t;

    int        exp_pt[$];
    clct_exp_t exp_cl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (pretrig) begin
            if (exp_pt.size() == 0) begin
                check("pretrig_unexpected", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                check("pretrig_cycle", 64'(cyc), 64'(exp_pt.pop_front()));
            end
        end
        if (clct_vld) begin
            if (exp_cl.size() == 0) begin
                check("clct_unexpected", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                clct_exp_t e;
                e = exp_cl.pop_front();
                check("clct_cycle", 64'(cyc), 64'(e.at));
                check("clct_fields", {clct_hit, clct_pid, clct_key, clct_subkey, clct_bend,
                                      clct_carry, clct_qlt}, 64'(e.fields));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [6:0] pat, input logic [7:0] key, input logic [9:0] sk,
                          input logic [4:0] bend, input logic [11:0] carry,
                          input logic [5:0] qlt);
        best_pat = pat; best_key = key; best_subkey = sk;
        best_bend = bend; best_carry = carry; best_qlt = qlt;
    endtask

    task automatic push_clct(input int at, input logic [47:0] f);
        clct_exp_t e;
        e.at = at;
        e.fields = f;
        exp_cl.push_back(e);
    endtask

    task automatic clear_cnt();
        cnt_clear = 1'b1;
        tick(1);
        cnt_clear = 1'b0;
        check("cnt_cleared", {cnt_pretrig, cnt_clct, cnt_drop, cnt_blocked}, 64'h0);
    endtask

    task automatic check_cnts(input string name, input int p, input int c, input int d,
                              input int b);
        check(name, {cnt_pretrig, cnt_clct, cnt_drop, cnt_blocked},
              {CNTW'(p), CNTW'(c), CNTW'(d), CNTW'(b)});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        reset = 1'b1; cnt_clear = 1'b0; seq_en = 1'b1;
        hit_thresh_pretrig = 3'd4; pid_thresh_pretrig = 4'd0;
        hit_thresh_postdrift = 3'd4; pid_thresh_postdrift = 4'd0;
        drift_delay = 2'd2; dead_time = 4'd0;
        set_in(7'h00, 8'h00, 10'h000, 5'h00, 12'h000, 6'h00);
        tick(3);
        check("reset_strobes", {pretrig, busy, clct_vld}, 64'h0);
        check("reset_fields", {clct_hit, clct_pid, clct_key, clct_subkey, clct_bend,
                               clct_carry, clct_qlt}, 64'h0);
        check_cnts("reset_cnts", 0, 0, 0, 0);
        reset = 1'b0;
        tick(2);

        // Basic latch: drift 2, dead 0.
        clear_cnt();
        t = cyc;
        set_in(7'h5A, 8'hC3, 10'h2A5, 5'h13, 12'hABC, 6'h2D);
        exp_pt.push_back(t + 1);
        push_clct(t + 4, {3'd5, 4'hA, 8'hC3, 10'h2A5, 5'h13, 12'hABC, 6'h2D});
        tick(2);
        check("basic_busy", 64'(busy), 64'h1);
        tick(2);
        set_in(7'h00, 8'h00, 10'h000, 5'h00, 12'h000, 6'h00);
        tick(3);
        check_cnts("basic_cnts", 1, 1, 0, 3);
        check("basic_key_held", 64'(clct_key), 64'hC3);

        // Post-drift drop: CLCT fields must keep the previous latch.
        clear_cnt();
        hit_thresh_postdrift = 3'd6;
        t = cyc;
        set_in(7'h5A, 8'h11, 10'h111, 5'h01, 12'h111, 6'h11);
        exp_pt.push_back(t + 1);
        tick(4);
        set_in(7'h00, 8'h00, 10'h000, 5'h00, 12'h000, 6'h00);
        tick(3);
        check_cnts("drop_cnts", 1, 0, 1, 3);
        check("drop_fields_held", {clct_hit, clct_pid, clct_key, clct_qlt},
              {3'd5, 4'hA, 8'hC3, 6'h2D});
        hit_thresh_postdrift = 3'd4;

        // Dead time 4, drift 0, continuous input: pretrig every 6 cycles.
        clear_cnt();
        drift_delay = 2'd0; dead_time = 4'd4;
        t = cyc;
        set_in(7'h4F, 8'h0F, 10'h0F0, 5'h0F, 12'hF0F, 6'h0F);
        for (int k = 0; k < 3; k++) begin
            exp_pt.push_back(t + 1 + 6 * k);
            push_clct(t + 2 + 6 * k, {3'd4, 4'hF, 8'h0F, 10'h0F0, 5'h0F, 12'hF0F, 6'h0F});
        end
        tick(18);
        set_in(7'h00, 8'h00, 10'h000, 5'h00, 12'h000, 6'h00);
        tick(2);
        check_cnts("dead_cnts", 3, 3, 0, 15);

        // seq_en low: qualifying input must be ignored.
        clear_cnt();
        seq_en = 1'b0;
        set_in(7'h7F, 8'h01, 10'h001, 5'h01, 12'h001, 6'h01);
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check("seqen_off_busy", 64'(busy), 64'h0);
        end
        set_in(7'h00, 8'h00, 10'h000, 5'h00, 12'h000, 6'h00);
        tick(1);
        check_cnts("seqen_off_cnts", 0, 0, 0, 0);

        // seq_en dropped mid-sequence: sequence still completes.
        drift_delay = 2'd2; dead_time = 4'd0;
        seq_en = 1'b1;
        t = cyc;
        set_in(7'h7F, 8'h7E, 10'h3FF, 5'h1F, 12'hFFF, 6'h3F);
        exp_pt.push_back(t + 1);
        push_clct(t + 4, {3'd7, 4'hF, 8'h7E, 10'h3FF, 5'h1F, 12'hFFF, 6'h3F});
        tick(1);
        seq_en = 1'b0;
        tick(3);
        set_in(7'h00, 8'h00, 10'h000, 5'h00, 12'h000, 6'h00);
        tick(3);
        check_cnts("seqen_mid_cnts", 1, 1, 0, 0);
        seq_en = 1'b1;

        // Reset during DRIFT aborts; a later pattern pre-triggers normally.
        drift_delay = 2'd3;
        t = cyc;
        set_in(7'h5A, 8'h22, 10'h022, 5'h02, 12'h022, 6'h02);
        exp_pt.push_back(t + 1);
        tick(1);
        set_in(7'h00, 8'h00, 10'h000, 5'h00, 12'h000, 6'h00);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst_mid_strobes", {pretrig, busy, clct_vld}, 64'h0);
        check_cnts("rst_mid_cnts", 0, 0, 0, 0);
        check("rst_mid_fields", {clct_hit, clct_pid, clct_key}, 64'h0);
        tick(6);
        drift_delay = 2'd0;
        t = cyc;
        set_in(7'h63, 8'h01, 10'h001, 5'h01, 12'h001, 6'h01);
        exp_pt.push_back(t + 1);
        push_clct(t + 2, {3'd6, 4'h3, 8'h01, 10'h001, 5'h01, 12'h001, 6'h01});
        tick(2);
        set_in(7'h00, 8'h00, 10'h000, 5'h00, 12'h000, 6'h00);
        tick(2);
        check_cnts("rst_rearm_cnts", 1, 1, 0, 1);

        // Saturation: 300 back-to-back sequences on 8-bit counters, then clear with pretrig.
        clear_cnt();
        t = cyc;
        set_in(7'h5A, 8'h55, 10'h155, 5'h15, 12'h555, 6'h15);
        for (int k = 0; k < 300; k++) begin
            exp_pt.push_back(t + 1 + 2 * k);
            push_clct(t + 2 + 2 * k, {3'd5, 4'hA, 8'h55, 10'h155, 5'h15, 12'h555, 6'h15});
        end
        tick(600);
        set_in(7'h00, 8'h00, 10'h000, 5'h00, 12'h000, 6'h00);
        tick(2);
        check_cnts("sat_cnts", 255, 255, 0, 255);
        t = cyc;
        set_in(7'h5A, 8'h55, 10'h155, 5'h15, 12'h555, 6'h15);
        cnt_clear = 1'b1;
        exp_pt.push_back(t + 1);
        tick(1);
        cnt_clear = 1'b0;
        set_in(7'h00, 8'h00, 10'h000, 5'h00, 12'h000, 6'h00);
        check("clr_vs_pretrig", {cnt_pretrig, cnt_clct}, 64'h0);
        tick(1);
        check("clr_then_drop", 64'(cnt_drop), 64'h1);

        for (int k = 0; k < 20 && (exp_pt.size() != 0 || exp_cl.size() != 0); k++) tick(1);
        check("pretrig_queue_empty", 64'(exp_pt.size()), 64'h0);
        check("clct_queue_empty", 64'(exp_cl.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clct_pretrig_sequencer.md
Name: clct_pretrig_sequencer

Overview:
- Sequential stage directly downstream of the 1-of-7 best-pattern sorter in the pattern finder.
- Watches the combinational best 1/2-strip pattern each clock and fires a pre-trigger on threshold.
- Waits a programmable drift delay, re-evaluates the then-current best pattern against post-drift thresholds, and latches a CLCT.
- Enforces a programmable dead time before re-arming, and keeps saturating event counters for VME readout.

Parameters:
MXPATB, 7, pattern width: [6:4] hit count, [3:0] pattern id
MXKEYBX, 8, key 1/2-strip width ({cfeb[2:0], key[4:0]})
MXXKYB, 10, 1/8-strip subkey width
MXBNDB, 5, bend width
MXPATC, 12, comparator-code carry width
MXQLTB, 6, post-fit quality width
MXCNTB, 16, event counter width

Ports:
clock  in  1  40 MHz main clock
reset  in  1  synchronous, active-high reset
best_pat  in  MXPATB  sorter best pattern {hits,pid}
best_key  in  MXKEYBX  sorter best key
best_bend  in  MXBNDB  sorter best bend
best_carry  in  MXPATC  sorter best carry
best_subkey  in  MXXKYB  sorter best subkey
best_qlt  in  MXQLTB  sorter best quality
seq_en  in  1  1 = sequencer armed; 0 = no new pre-triggers
hit_thresh_pretrig  in  3  min hits to pre-trigger
pid_thresh_pretrig  in  4  min pid to pre-trigger
hit_thresh_postdrift  in  3  min hits to latch CLCT
pid_thresh_postdrift  in  4  min pid to latch CLCT
drift_delay  in  2  extra cycles between pre-trigger and evaluation
dead_time  in  4  cycles blocked after evaluation
cnt_clear  in  1  synchronous clear of all counters
pretrig  out  1  one-cycle pre-trigger pulse
busy  out  1  high whenever state != IDLE
clct_vld  out  1  one-cycle CLCT strobe
clct_hit  out  3  latched hits
clct_pid  out  4  latched pid
clct_key  out  MXKEYBX  latched key
clct_subkey  out  MXXKYB  latched subkey
clct_bend  out  MXBNDB  latched bend
clct_carry  out  MXPATC  latched carry
clct_qlt  out  MXQLTB  latched quality
cnt_pretrig  out  MXCNTB  pre-triggers issued
cnt_clct  out  MXCNTB  CLCTs latched
cnt_drop  out  MXCNTB  pre-triggers failing post-drift
cnt_blocked  out  MXCNTB  over-threshold cycles seen while busy

Behaviour:
- Reset: state IDLE; every output 0 (strobes, busy, all clct_* fields, all counters).
- Reset asserted mid-sequence aborts the sequence. Nothing is latched and no counter increments on that cycle.
- Qualifiers: pre_ok = best_pat[6:4]>=hit_thresh_pretrig && best_pat[3:0]>=pid_thresh_pretrig. post_ok is the same test using the postdrift thresholds. Both comparisons are unsigned.
- State machine:
  - IDLE: if seq_en && pre_ok at cycle T, register pretrig=1 at T+1, load drift counter with drift_delay, go to DRIFT.
  - DRIFT: decrement the counter each cycle; when it is 0, go to EVAL. The cycle after pretrig is counted, so the evaluation sample is taken at T+1+drift_delay.
  - EVAL (one cycle): sample the sorter inputs.
    - If post_ok: register all clct_* fields from the inputs (hit=best_pat[6:4], pid=best_pat[3:0]) and pulse clct_vld at T+2+drift_delay.
    - Otherwise: increment cnt_drop, and clct_* holds its previous values.
    - Load dead counter with dead_time. Go to DEAD if dead_time!=0, else IDLE.
  - DEAD: decrement; at 0 go to IDLE.
- Re-arm timing: IDLE may pre-trigger on its first cycle. Minimum spacing between pretrig pulses is 2+drift_delay+dead_time cycles.
- busy=1 in DRIFT, EVAL and DEAD.
- cnt_blocked increments on each cycle where busy && seq_en && pre_ok.
- seq_en deasserted mid-sequence does not abort the sequence; it only prevents the next pre-trigger.
- clct_* fields are held until the next successful EVAL. They are not cleared by clct_vld falling.
- Counters:
  - Saturate at all-ones; no wrap.
  - cnt_clear takes priority over a same-cycle increment, so the result is 0.
  - cnt_pretrig and cnt_clct increment in the same cycle their strobe is registered.
- Threshold or delay inputs changed mid-sequence take effect at their next point of use; counters already loaded are unaffected.

Test Plan:
- Reset mid-sequence: assert reset during DRIFT -> next cycle busy=0, pretrig=0, all counters 0; a later valid pattern pre-triggers normally.
- Basic latch: thresholds 4/0 and 4/0, drift_delay=2, dead_time=0; inject best_pat=7'h5A (hits 5, pid 10), best_key=8'hC3 from cycle 10 -> pretrig at 11, clct_vld at 14 with clct_hit=5, clct_pid=10, clct_key=8'hC3; cnt_pretrig=1, cnt_clct=1.
- Post-drift drop: hit_thresh_postdrift=6, best_pat=7'h5A held -> pretrig pulses, no clct_vld, cnt_drop=1, clct_* retain old values.
- Dead time and blocking: drift_delay=0, dead_time=4, continuous qualifying input -> pretrig pulses every 6 cycles; cnt_blocked increments 5 per sequence.
- Counter saturation and clear: preload by running 65537 sequences -> cnt_pretrig=16'hFFFF. Pulse cnt_clear in the same cycle as a pretrig -> counter reads 0.
- seq_en=0 with qualifying input -> no pretrig, busy=0, cnt_blocked stays 0.
